mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage of the 5-stage CPU.
- Sits between the EX_MEM pipeline register and the MEM_WB pipeline register.
- Drives the data-memory request/acknowledge interface, which has variable latency.
- Freezes upstream stages while an access is outstanding and presents the completed result, or a bubble, to MEM_WB.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- DW, 32, data width of the register file and memory word.
- AW, 32, memory address width (taken from the ALU result).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- valid_i  input  1  EX_MEM holds a live instruction.
- M_i  input  2  {MemRead, MemWrite}.
- WB_i  input  2  {RegWrite, MemtoReg} from EX_MEM.
- ALU_o_i  input  DW  ALU result; also the memory address (low AW bits).
- wdata_i  input  DW  store data.
- Rd_i  input  5  destination register.
- stall_o  output  1  holds PC, IF_ID, ID_EX and EX_MEM.
- WB_o  output  2  to MEM_WB.
- read_data_o  output  DW  to MEM_WB.
- ALU_o_o  output  DW  to MEM_WB.
- Rd_o  output  5  to MEM_WB.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  1 = write, 0 = read.
- mem_addr_o  output  AW  request address.
- mem_wdata_o  output  DW  request write data.
- mem_ack_i  input  1  memory completion, single-cycle pulse.
- mem_rdata_i  input  DW  read data, valid when mem_ack_i=1.
- stall_cnt_o  output  CNT_W  total stall cycles.

Behaviour:
- Reset (rst_i=0, asynchronous, takes effect immediately, including mid-access):
  - state=IDLE.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - rdata_q=0, stall_cnt_o=0.
  - Combinational outputs follow IDLE rules.
  - Any outstanding request is abandoned; a later mem_ack_i is ignored.
- memop = valid_i & (M_i[1] | M_i[0]). If both bits are set, treat it as a write.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - memop=0: pass-through. stall_o=0, WB_o=valid_i?WB_i:0, Rd_o=valid_i?Rd_i:0, ALU_o_o=ALU_o_i, read_data_o=0. Stays IDLE.
  - memop=1:
    - stall_o=1 in the same cycle (combinational).
    - Bubble out: WB_o=0, Rd_o=0, read_data_o=0.
    - At the clock edge: latch addr, wdata, we into the mem_* registers; set mem_req_o=1; go to BUSY.
- BUSY:
  - stall_o=1, bubble out.
  - mem_req_o and mem_we/addr/wdata held stable until ack.
  - On mem_ack_i=1: mem_req_o←0, rdata_q←(we?0:mem_rdata_i), go to RESP.
- RESP:
  - stall_o=0.
  - WB_o=WB_i, Rd_o=Rd_i, ALU_o_o=ALU_o_i, read_data_o=rdata_q.
  - EX_MEM and MEM_WB both advance at this edge.
  - Unconditionally return to IDLE; the held instruction is never re-issued.
- Access latency: a memop instruction spends 2+L cycles in this stage, where L ≥ 1 is the number of cycles from mem_req_o rising to mem_ack_i.
- mem_ack_i outside BUSY is ignored. An ack is never possible in the same cycle the request is issued, because mem_req_o is registered.
- ALU_o_o always equals ALU_o_i, combinationally.
- stall_cnt_o:
  - Increments by 1 on every edge where stall_o=1.
  - Saturates at all-ones; never wraps.
- Back-to-back memops: the second one enters IDLE on the cycle after RESP and stalls again. There is no overlap.

Optional Feature:
- Macro MEM_ALIGN_CHK_EN.
- Defined:
  - Adds output misalign_o (1 bit).
  - In IDLE, a memop whose ALU_o_i[1:0]≠0 issues no request.
  - misalign_o=1 for that single cycle, stall_o=0, and a bubble goes to MEM_WB (WB_o=0). The instruction is squashed.
  - misalign_o is 0 after reset.
- Undefined:
  - misalign_o is not present.
  - Low address bits are passed to memory unchecked.

Test Plan:
- Reset mid-access: rst_i low during BUSY -> mem_req_o=0 immediately, stall_o=0, stall_cnt_o=0. An ack arriving 2 cycles later produces no output change.
- ALU op: valid_i=1, M_i=00, WB_i=10, Rd_i=5, ALU_o_i=0x1234 -> same cycle: stall_o=0, WB_o=10, Rd_o=5, ALU_o_o=0x1234, read_data_o=0. No mem_req_o.
- Load, L=3: M_i=10, ALU_o_i=0x40, mem_rdata_i=0xDEADBEEF on ack -> stall_o high 4 cycles, mem_addr_o=0x40, mem_we_o=0. RESP cycle: WB_o=WB_i, read_data_o=0xDEADBEEF. stall_cnt_o=4.
- Store, L=1: M_i=01, wdata_i=0xA5A5A5A5, ALU_o_i=0x8 -> mem_we_o=1, mem_wdata_o=0xA5A5A5A5 held until ack. read_data_o=0 in RESP. Exactly one request pulse.
- Back-to-back: load then load, L=2 each -> two separate requests, 6 total stall cycles, no re-issue of the first. A spurious ack in IDLE is ignored.
- MEM_ALIGN_CHK_EN defined, load at 0x42 -> misalign_o=1 for 1 cycle, mem_req_o stays 0, WB_o=0, stall_o=0.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a variable-latency data-memory handshake, freezes upstream while busy.
// Optional macro MEM_ALIGN_CHK_EN squashes memory ops whose address is not word aligned.
module mem_access_stage #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [1:0]       M_i,
    input  logic [1:0]       WB_i,
    input  logic [DW-1:0]    ALU_o_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic [4:0]       Rd_i,
    output logic             stall_o,
    output logic [1:0]       WB_o,
    output logic [DW-1:0]    read_data_o,
    output logic [DW-1:0]    ALU_o_o,
    output logic [4:0]       Rd_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AW-1:0]    mem_addr_o,
    output logic [DW-1:0]    mem_wdata_o,
    input  logic             mem_ack_i,
    input  logic [DW-1:0]    mem_rdata_i,
`ifdef MEM_ALIGN_CHK_EN
    output logic             misalign_o,
`endif
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [DW-1:0] rdata_q;
    logic          memop;
    logic          issue;

    assign memop = valid_i & (M_i[1] | M_i[0]);

`ifdef MEM_ALIGN_CHK_EN
    logic misaligned;
    assign misaligned = memop & (ALU_o_i[1:0] != 2'b00);
    assign issue      = memop & ~misaligned;
    assign misalign_o = (state == IDLE) & misaligned;
`else
    assign issue = memop;
`endif

    // A memop that is not issued (squashed) still produces a bubble, never a pass-through.
    always_comb begin
        stall_o     = 1'b0;
        WB_o        = 2'b00;
        Rd_o        = 5'd0;
        read_data_o = '0;
        ALU_o_o     = ALU_o_i;
        case (state)
            IDLE: begin
                if (issue) begin
                    stall_o = 1'b1;
                end else if (valid_i && !memop) begin
                    WB_o = WB_i;
                    Rd_o = Rd_i;
                end
            end
            BUSY: stall_o = 1'b1;
            RESP: begin
                WB_o        = WB_i;
                Rd_o        = Rd_i;
                read_data_o = rdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= M_i[0];
                        mem_addr_o  <= ALU_o_i[AW-1:0];
                        mem_wdata_o <= wdata_i;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        rdata_q   <= mem_we_o ? '0 : mem_rdata_i;
                        state     <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver pushes expected results, a monitor pops and compares,
// and a memory responder answers requests with per-access latency chosen by the driver.
module tb_mem_access_stage;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic [1:0]       M_i;
    logic [1:0]       WB_i;
    logic [DW-1:0]    ALU_o_i;
    logic [DW-1:0]    wdata_i;
    logic [4:0]       Rd_i;
    logic             stall_o;
    logic [1:0]       WB_o;
    logic [DW-1:0]    read_data_o;
    logic [DW-1:0]    ALU_o_o;
    logic [4:0]       Rd_o;
    logic             mem_req_o;
    logic             mem_we_o;
    logic [AW-1:0]    mem_addr_o;
    logic [DW-1:0]    mem_wdata_o;
    logic             mem_ack_i;
    logic [DW-1:0]    mem_rdata_i;
    logic [CNT_W-1:0] stall_cnt_o;
`ifdef MEM_ALIGN_CHK_EN
    logic             misalign_o;
`endif

    mem_access_stage #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .M_i(M_i), .WB_i(WB_i),
        .ALU_o_i(ALU_o_i), .wdata_i(wdata_i), .Rd_i(Rd_i), .stall_o(stall_o),
        .WB_o(WB_o), .read_data_o(read_data_o), .ALU_o_o(ALU_o_o), .Rd_o(Rd_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
`ifdef MEM_ALIGN_CHK_EN
        .misalign_o(misalign_o),
`endif
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  wb;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        int          stalls;
        int          cum;
        logic        mis;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] phys_mem [logic [31:0]];

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;
    bit aborted     = 1'b0;
    int total_stalls = 0;
    int abandon_gen = 0;
    int spur_req    = 0;
    int spur_done   = 0;

    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the instruction must look like when it leaves the stage.
    task automatic apply_stimulus(input bit v, input logic [1:0] m, input logic [1:0] wb,
                                  input logic [31:0] alu, input logic [31:0] wd,
                                  input logic [4:0] rd, input int lat);
        exp_t e;
        req_t r;
        bit   memop;
        bit   mis;
        int   budget;
        memop = v && (m != 2'b00);
        mis   = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
        mis = memop && (alu[1:0] != 2'b00);
`endif
        e.alu = alu;
        e.mis = mis;
        if (memop && !mis) begin
            r.we = m[0]; r.addr = alu; r.wdata = wd; r.lat = lat;
            req_q.push_back(r);
            if (m[0]) begin
                ref_mem[alu] = wd;
                e.rdata = 32'h0;
            end else begin
                e.rdata = ref_mem.exists(alu) ? ref_mem[alu] : mem_default(alu);
            end
            e.wb = wb; e.rd = rd; e.stalls = 1 + lat;
        end else begin
            e.wb = (v && !memop) ? wb : 2'b00;
            e.rd = (v && !memop) ? rd : 5'd0;
            e.rdata = 32'h0;
            e.stalls = 0;
        end
        total_stalls += e.stalls;
        e.cum = (total_stalls > CNT_MAX) ? CNT_MAX : total_stalls;
        exp_q.push_back(e);
        valid_i = v; M_i = m; WB_i = wb; ALU_o_i = alu; wdata_i = wd; Rd_i = rd;
        budget = 0;
        forever begin
            @(negedge clk_i);
            if (!stall_o) break;
            budget++;
            if (budget > 40) begin
                check_output("stall_timeout", 32'(stall_o), 32'h0);
                aborted = 1'b1;
                break;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every non-stalled cycle hands one instruction to MEM_WB.
    initial begin
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk_i);
            if (!mon_en) begin
                run = 0;
                continue;
            end
            if (stall_o) begin
                run++;
            end else begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_output", 32'(WB_o), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_output("WB_o", 32'(WB_o), 32'(e.wb));
                    check_output("Rd_o", 32'(Rd_o), 32'(e.rd));
                    check_output("ALU_o_o", ALU_o_o, e.alu);
                    check_output("read_data_o", read_data_o, e.rdata);
                    check_output("stall_cycles", 32'(run), 32'(e.stalls));
                    check_output("stall_cnt_o", 32'(stall_cnt_o), 32'(e.cum));
`ifdef MEM_ALIGN_CHK_EN
                    check_output("misalign_o", 32'(misalign_o), 32'(e.mis));
                    if (e.mis) check_output("misalign_req", 32'(mem_req_o), 32'h0);
`endif
                end
                run = 0;
            end
        end
    end

    // Memory responder: checks each request against the model, acks after the chosen latency.
    initial begin
        req_t r;
        int   snap;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (mem_ack_i) begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = '0;
            end
            if (mem_req_o && rst_i) begin
                snap = abandon_gen;
                if (req_q.size() == 0) begin
                    check_output("unexpected_request", 32'(mem_req_o), 32'h0);
                    r.we = 1'b0; r.addr = mem_addr_o; r.wdata = '0; r.lat = 1;
                end else begin
                    r = req_q.pop_front();
                    check_output("mem_we_o", 32'(mem_we_o), 32'(r.we));
                    check_output("mem_addr_o", mem_addr_o, r.addr);
                    if (r.we) check_output("mem_wdata_o", mem_wdata_o, r.wdata);
                end
                for (int k = 1; k <= r.lat; k++) begin
                    if (k > 1) @(negedge clk_i);
                    if (abandon_gen == snap) begin
                        check_output("req_held", 32'(mem_req_o), 32'h1);
                        check_output("addr_held", mem_addr_o, r.addr);
                        if (r.we) check_output("wdata_held", mem_wdata_o, r.wdata);
                    end
                end
                mem_ack_i = 1'b1;
                if (r.we) begin
                    mem_rdata_i = $urandom;
                    phys_mem[r.addr] = r.wdata;
                end else begin
                    mem_rdata_i = phys_mem.exists(r.addr) ? phys_mem[r.addr] : mem_default(r.addr);
                end
                @(negedge clk_i);
                mem_ack_i   = 1'b0;
                mem_rdata_i = '0;
                if (abandon_gen == snap) check_output("req_single_pulse", 32'(mem_req_o), 32'h0);
            end else if (spur_done != spur_req) begin
                spur_done++;
                mem_ack_i   = 1'b1;
                mem_rdata_i = 32'hBAD0_BAD0;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] alu;
        rst_i = 1'b0; valid_i = 1'b0; M_i = 2'b00; WB_i = 2'b00;
        ALU_o_i = '0; wdata_i = '0; Rd_i = 5'd0;
        #12;
        check_output("rst_req", 32'(mem_req_o), 32'h0);
        check_output("rst_we", 32'(mem_we_o), 32'h0);
        check_output("rst_addr", mem_addr_o, 32'h0);
        check_output("rst_wdata", mem_wdata_o, 32'h0);
        check_output("rst_stall", 32'(stall_o), 32'h0);
        check_output("rst_cnt", 32'(stall_cnt_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        ref_mem[32'h40]  = 32'hDEAD_BEEF;
        phys_mem[32'h40] = 32'hDEAD_BEEF;
        mon_en = 1'b1;

        // Directed: ALU pass-through, load L=3, store L=1, bubble with stray ack, back-to-back loads.
        apply_stimulus(1, 2'b00, 2'b10, 32'h1234, 32'h0, 5'd5, 0);
        if (!aborted) apply_stimulus(1, 2'b10, 2'b11, 32'h40, 32'h0, 5'd7, 3);
        if (!aborted) apply_stimulus(1, 2'b01, 2'b00, 32'h8, 32'hA5A5_A5A5, 5'd0, 1);
        spur_req++;
        if (!aborted) apply_stimulus(0, 2'b00, 2'b10, 32'h0, 32'h0, 5'd3, 0);
        if (!aborted) apply_stimulus(1, 2'b10, 2'b11, 32'h40, 32'h0, 5'd1, 2);
        if (!aborted) apply_stimulus(1, 2'b10, 2'b11, 32'h8, 32'h0, 5'd2, 2);
        if (!aborted) apply_stimulus(1, 2'b11, 2'b01, 32'h10, 32'h1357_9BDF, 5'd4, 1);
`ifdef MEM_ALIGN_CHK_EN
        if (!aborted) apply_stimulus(1, 2'b10, 2'b11, 32'h42, 32'h0, 5'd6, 1);
`endif

        // Reset in the middle of an access; the late ack must not resurrect the instruction.
        if (!aborted) begin
            mon_en = 1'b0;
            req_q.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0, lat: 5});
            valid_i = 1'b1; M_i = 2'b10; WB_i = 2'b11; ALU_o_i = 32'h80; Rd_i = 5'd9;
            repeat (3) @(negedge clk_i);
            #2;
            abandon_gen++;
            rst_i = 1'b0; valid_i = 1'b0; M_i = 2'b00;
            #1;
            check_output("midrst_req", 32'(mem_req_o), 32'h0);
            check_output("midrst_stall", 32'(stall_o), 32'h0);
            check_output("midrst_cnt", 32'(stall_cnt_o), 32'h0);
            check_output("midrst_addr", mem_addr_o, 32'h0);
            @(negedge clk_i);
            rst_i = 1'b1;
            repeat (4) begin
                @(negedge clk_i);
                check_output("postrst_req", 32'(mem_req_o), 32'h0);
                check_output("postrst_stall", 32'(stall_o), 32'h0);
                check_output("postrst_wb", 32'(WB_o), 32'h0);
                check_output("postrst_cnt", 32'(stall_cnt_o), 32'h0);
            end
            @(posedge clk_i);
            #1;
            total_stalls = 0;
            mon_en = 1'b1;
        end

        // Random traffic; the narrow counter saturates along the way.
        for (int i = 0; i < 250 && !aborted; i++) begin
            alu = 32'h100 + (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 3) == 0) alu = alu + 32'($urandom_range(1, 3));
            apply_stimulus($urandom_range(0, 9) != 0, 2'($urandom), 2'($urandom), alu,
                           $urandom, 5'($urandom), $urandom_range(1, 5));
        end

        mon_en  = 1'b0;
        valid_i = 1'b0; M_i = 2'b00;
        repeat (3) @(negedge clk_i);
        check_output("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check_output("req_q_drained", 32'(req_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
